// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the decoder.
package cpu_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        HALT
    } fetch_state_t;

    // All-zero word ends the program; the decoder uses the same constant.
    localparam logic [31:0] HALT_INSTR     = 32'd0;
    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;

    // Branch targets are word aligned; the Thumb bit and bit 1 are discarded.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, synchronous ROM read sequencing,
// valid/stall handshake to the decoder, BX redirect and halt detection.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branchTaken,
    input  logic [31:0]       branchTarget,
    output logic              romRdEn,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [31:0]       romData,
    output logic [31:0]       instruccion,
    output logic              instrValid,
    output logic [31:0]       pcOut,
    output logic [31:0]       pcPlus8,
    output logic              halted
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  pcOut_q;
    logic [31:0]  pcPlus8_q;
    logic         romRdEn_q;
    logic         instrValid_q;
    logic         halted_q;

    logic [31:0]  pcSeq_d;
    logic [31:0]  pcRedirect_d;
    logic         redirectOk;

    // Sequential next pc, aligned redirect target, and whether a redirect applies in this state.
    always_comb begin
        pcSeq_d      = pc_q + PC_STEP;
        pcRedirect_d = alignWord(branchTarget);
        redirectOk   = branchTaken && (state_q == REQ || state_q == WAIT || state_q == VALID);
    end

    // Fetch sequencer with registered outputs; redirect beats stall beats normal sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            pcOut_q      <= RESET_PC;
            pcPlus8_q    <= RESET_PC + PC_READ_OFFSET;
            romRdEn_q    <= 1'b0;
            instrValid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else if (redirectOk) begin
            state_q      <= REQ;
            pc_q         <= pcRedirect_d;
            romRdEn_q    <= 1'b1;
            instrValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        romRdEn_q <= 1'b1;
                    end
                end
                REQ: begin
                    state_q   <= WAIT;
                    romRdEn_q <= 1'b0;
                end
                WAIT: begin
                    state_q      <= VALID;
                    instr_q      <= romData;
                    pcOut_q      <= pc_q;
                    pcPlus8_q    <= pc_q + PC_READ_OFFSET;
                    instrValid_q <= 1'b1;
                end
                VALID: begin
                    if (!stall) begin
                        instrValid_q <= 1'b0;
                        if (instr_q == HALT_INSTR) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            pc_q      <= pcSeq_d;
                            romRdEn_q <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q      <= IDLE;
                    romRdEn_q    <= 1'b0;
                    instrValid_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; the ROM address is a slice of pc.
    always_comb begin
        romRdEn     = romRdEn_q;
        romAddr     = pc_q[ADDR_W+1:2];
        instruccion = instr_q;
        instrValid  = instrValid_q;
        pcOut       = pcOut_q;
        pcPlus8     = pcPlus8_q;
        halted      = halted_q;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a one-cycle-latency ROM model.
module tb_instruction_fetch;

    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rom [0:(1<<ADDR_W)-1];

    // Main instance, RESET_PC = 0
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              branchTaken = 1'b0;
    logic [31:0]       branchTarget = 32'd0;
    logic              romRdEn;
    logic [ADDR_W-1:0] romAddr;
    logic [31:0]       romData = 32'd0;
    logic [31:0]       instruccion;
    logic              instrValid;
    logic [31:0]       pcOut;
    logic [31:0]       pcPlus8;
    logic              halted;

    // Wrap instance, RESET_PC at top of address space
    logic              wRst_n = 1'b0;
    logic              wStart = 1'b0;
    logic              wRomRdEn;
    logic [ADDR_W-1:0] wRomAddr;
    logic [31:0]       wRomData = 32'd0;
    logic [31:0]       wInstr;
    logic              wValid;
    logic [31:0]       wPcOut;
    logic [31:0]       wPcPlus8;
    logic              wHalted;

    logic [31:0] expWords [4];

    always #5 clk = ~clk;

    instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .romRdEn(romRdEn), .romAddr(romAddr), .romData(romData),
        .instruccion(instruccion), .instrValid(instrValid),
        .pcOut(pcOut), .pcPlus8(pcPlus8), .halted(halted)
    );

    instruction_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst_n(wRst_n), .start(wStart), .stall(1'b0),
        .branchTaken(1'b0), .branchTarget(32'd0),
        .romRdEn(wRomRdEn), .romAddr(wRomAddr), .romData(wRomData),
        .instruccion(wInstr), .instrValid(wValid),
        .pcOut(wPcOut), .pcPlus8(wPcPlus8), .halted(wHalted)
    );

    // Synchronous ROMs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (romRdEn) romData <= rom[romAddr];
        if (wRomRdEn) wRomData <= rom[wRomAddr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++; if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", instrValid); end
        checks++; if (romRdEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_rden got %b expected 0", romRdEn); end
        checks++; if (romAddr !== 10'h000) begin errors++; $display("[TB] FAIL reset_addr got %h expected 000", romAddr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %b expected 0", halted); end
        checks++; if (instruccion !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr got %h expected 0", instruccion); end
        checks++; if (pcOut !== 32'd0) begin errors++; $display("[TB] FAIL reset_pcout got %h expected 0", pcOut); end
        checks++; if (pcPlus8 !== 32'd8) begin errors++; $display("[TB] FAIL reset_pcplus8 got %h expected 8", pcPlus8); end
    endtask

    task automatic test_straight_line();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (romRdEn !== 1'b1 || romAddr !== 10'(i)) begin errors++; $display("[TB] FAIL line_req%0d got rden=%b addr=%h expected rden=1 addr=%h", i, romRdEn, romAddr, 10'(i)); end
            checks++; if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL line_req_valid%0d got %b expected 0", i, instrValid); end
            tick();
            checks++; if (romRdEn !== 1'b0 || instrValid !== 1'b0) begin errors++; $display("[TB] FAIL line_wait%0d got rden=%b valid=%b expected 0 0", i, romRdEn, instrValid); end
            tick();
            checks++; if (instrValid !== 1'b1 || instruccion !== expWords[i]) begin errors++; $display("[TB] FAIL line_word%0d got valid=%b instr=%h expected 1 %h", i, instrValid, instruccion, expWords[i]); end
            checks++; if (pcOut !== 32'(4*i) || pcPlus8 !== 32'(4*i+8)) begin errors++; $display("[TB] FAIL line_pc%0d got pcOut=%h pcPlus8=%h expected %h %h", i, pcOut, pcPlus8, 32'(4*i), 32'(4*i+8)); end
            tick();
        end
        checks++; if (halted !== 1'b1 || instrValid !== 1'b0) begin errors++; $display("[TB] FAIL line_halt got halted=%b valid=%b expected 1 0", halted, instrValid); end
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0100;
        tick();
        branchTaken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (romRdEn !== 1'b0 || halted !== 1'b1 || instrValid !== 1'b0) begin errors++; $display("[TB] FAIL halt_hold%0d got rden=%b halted=%b valid=%b expected 0 1 0", i, romRdEn, halted, instrValid); end
            tick();
        end
    endtask

    task automatic test_stall();
        rst_n = 1'b0;
        tick();
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL stall_rst_halted got %b expected 0", halted); end
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        checks++; if (instrValid !== 1'b1 || pcOut !== 32'h4) begin errors++; $display("[TB] FAIL stall_setup got valid=%b pcOut=%h expected 1 4", instrValid, pcOut); end
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (instrValid !== 1'b1 || instruccion !== 32'hE2822002 || pcOut !== 32'h4 || romRdEn !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold%0d got valid=%b instr=%h pcOut=%h rden=%b expected 1 e2822002 4 0", i, instrValid, instruccion, pcOut, romRdEn); end
        end
        stall = 1'b0;
        tick();
        checks++; if (romRdEn !== 1'b1 || romAddr !== 10'h002 || instrValid !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got rden=%b addr=%h valid=%b expected 1 002 0", romRdEn, romAddr, instrValid); end
    endtask

    task automatic test_branch();
        tick();
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0041;
        tick();
        branchTaken = 1'b0;
        checks++; if (romRdEn !== 1'b1 || romAddr !== 10'h010 || instrValid !== 1'b0) begin errors++; $display("[TB] FAIL branch_req got rden=%b addr=%h valid=%b expected 1 010 0", romRdEn, romAddr, instrValid); end
        tick();
        checks++; if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL branch_wait got valid=%b expected 0", instrValid); end
        tick();
        checks++; if (instrValid !== 1'b1 || instruccion !== 32'hE3A00005) begin errors++; $display("[TB] FAIL branch_word got valid=%b instr=%h expected 1 e3a00005", instrValid, instruccion); end
        checks++; if (pcOut !== 32'h40 || pcPlus8 !== 32'h48) begin errors++; $display("[TB] FAIL branch_pc got pcOut=%h pcPlus8=%h expected 40 48", pcOut, pcPlus8); end
    endtask

    task automatic test_branch_stall();
        stall        = 1'b1;
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0020;
        tick();
        stall       = 1'b0;
        branchTaken = 1'b0;
        checks++; if (instrValid !== 1'b0 || romRdEn !== 1'b1 || romAddr !== 10'h008) begin errors++; $display("[TB] FAIL bstall_req got valid=%b rden=%b addr=%h expected 0 1 008", instrValid, romRdEn, romAddr); end
        tick();
        tick();
        checks++; if (instrValid !== 1'b1 || instruccion !== 32'hE1A0F00E || pcOut !== 32'h20) begin errors++; $display("[TB] FAIL bstall_word got valid=%b instr=%h pcOut=%h expected 1 e1a0f00e 20", instrValid, instruccion, pcOut); end
    endtask

    task automatic test_reset_mid();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (instrValid !== 1'b0 || halted !== 1'b0 || romRdEn !== 1'b0 || romAddr !== 10'h000) begin errors++; $display("[TB] FAIL rmid_state got valid=%b halted=%b rden=%b addr=%h expected 0 0 0 000", instrValid, halted, romRdEn, romAddr); end
        checks++; if (instruccion !== 32'd0 || pcOut !== 32'd0) begin errors++; $display("[TB] FAIL rmid_regs got instr=%h pcOut=%h expected 0 0", instruccion, pcOut); end
        branchTaken  = 1'b1;
        branchTarget = 32'h0000_0100;
        tick();
        branchTaken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (romRdEn !== 1'b0 || romAddr !== 10'h000 || instrValid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_idle%0d got rden=%b addr=%h valid=%b expected 0 000 0", i, romRdEn, romAddr, instrValid); end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (romRdEn !== 1'b1 || romAddr !== 10'h000) begin errors++; $display("[TB] FAIL rmid_restart got rden=%b addr=%h expected 1 000", romRdEn, romAddr); end
    endtask

    task automatic test_wrap();
        wRst_n = 1'b0;
        tick();
        checks++; if (wRomAddr !== 10'h3FF || wPcOut !== 32'hFFFF_FFFC || wPcPlus8 !== 32'h4) begin errors++; $display("[TB] FAIL wrap_reset got addr=%h pcOut=%h pcPlus8=%h expected 3ff fffffffc 4", wRomAddr, wPcOut, wPcPlus8); end
        wRst_n = 1'b1;
        wStart = 1'b1;
        tick();
        wStart = 1'b0;
        checks++; if (wRomRdEn !== 1'b1 || wRomAddr !== 10'h3FF) begin errors++; $display("[TB] FAIL wrap_req1 got rden=%b addr=%h expected 1 3ff", wRomRdEn, wRomAddr); end
        tick();
        tick();
        checks++; if (wValid !== 1'b1 || wInstr !== 32'hEAFFFFFE || wPcOut !== 32'hFFFF_FFFC || wPcPlus8 !== 32'h4) begin errors++; $display("[TB] FAIL wrap_word1 got valid=%b instr=%h pcOut=%h pcPlus8=%h expected 1 eafffffe fffffffc 4", wValid, wInstr, wPcOut, wPcPlus8); end
        tick();
        checks++; if (wRomRdEn !== 1'b1 || wRomAddr !== 10'h000) begin errors++; $display("[TB] FAIL wrap_req2 got rden=%b addr=%h expected 1 000", wRomRdEn, wRomAddr); end
        tick();
        tick();
        checks++; if (wValid !== 1'b1 || wPcOut !== 32'h0 || wInstr !== 32'hE2811001) begin errors++; $display("[TB] FAIL wrap_word2 got valid=%b pcOut=%h instr=%h expected 1 0 e2811001", wValid, wPcOut, wInstr); end
    endtask

    // Load the ROM image, then run each scenario in order.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'hE1A00000;
        rom[0]     = 32'hE2811001;
        rom[1]     = 32'hE2822002;
        rom[2]     = 32'hE0803001;
        rom[3]     = 32'h0000_0000;
        rom[8]     = 32'hE1A0F00E;
        rom[16]    = 32'hE3A00005;
        rom[1023]  = 32'hEAFFFFFE;
        expWords[0] = 32'hE2811001;
        expWords[1] = 32'hE2822002;
        expWords[2] = 32'hE0803001;
        expWords[3] = 32'h0000_0000;

        test_reset();
        test_straight_line();
        test_stall();
        test_branch();
        test_branch_stall();
        test_reset_mid();
        test_wrap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the instruction decoder. It holds the program counter and reads 32-bit words from a synchronous instruction ROM with one-cycle read latency. It presents each word to the decoder with a valid/stall handshake and redirects on a taken branch-and-exchange. After the all-zero halt word has been consumed, it stops fetching until reset.

## Interface
- ADDR_W, 10, ROM word-address width; ROM spans 2^(ADDR_W+2) bytes
- RESET_PC, 32'h0000_0000, byte address loaded on reset; bits [1:0] must be 0
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  leave IDLE and begin fetching at pc
- stall  in  1  downstream not accepting; holds the current word
- branchTaken  in  1  redirect request (BX resolved), single-cycle pulse
- branchTarget  in  32  redirect byte address; bits [1:0] forced to 0 (Thumb bit ignored)
- romRdEn  out  1  ROM read strobe
- romAddr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2]
- romData  in  32  ROM read data, valid the cycle after romRdEn
- instruccion  out  32  registered instruction word for the decoder
- instrValid  out  1  instruccion is valid; drives the decoder enable
- pcOut  out  32  byte address of instruccion
- pcPlus8  out  32  pcOut + 8, the architectural PC read value
- halted  out  1  halt word consumed; fetch stopped

## Operation
- States:
  - IDLE: waits for start.
  - REQ: romRdEn=1, romAddr from pc.
  - WAIT: ROM data returning; captured into instruccion at the end of this cycle.
  - VALID: instrValid=1.
  - HALT: halted=1.
- Transitions:
  - IDLE→REQ when start=1.
  - REQ→WAIT always.
  - WAIT→VALID always; instruccion<=romData, pcOut<=pc.
  - VALID with stall=1: stay, all outputs held.
  - VALID with stall=0 (accepted) and instruccion==0: →HALT.
  - VALID with stall=0 and instruccion≠0: pc<=pc+4, →REQ.
- Redirect: branchTaken=1 in REQ, WAIT or VALID → pc<={branchTarget[31:2],2'b00}, →REQ.
  - Any in-flight ROM data is discarded.
  - instrValid drops on the next cycle.
  - branchTaken is ignored in IDLE and HALT.
- Priority: rst_n low > branchTaken > stall > normal sequencing.
- The halt word is presented once as valid so the decoder can raise done. It is not refetched.
- Arithmetic:
  - pc+4 wraps modulo 2^32.
  - romAddr truncation wraps at 2^(ADDR_W+2) bytes. No error is flagged.
  - pcPlus8 = pcOut+8, modulo 2^32.
- Reset values:
  - State IDLE, pc=RESET_PC.
  - instruccion=0, pcOut=RESET_PC, pcPlus8=RESET_PC+8.
  - instrValid=0, romRdEn=0, romAddr=RESET_PC[ADDR_W+1:2], halted=0.
- Reset mid-operation discards the pending fetch and the held word. start must be reasserted.

## Timing
- Edge E0 samples start=1 in IDLE. The REQ cycle follows E0, WAIT follows E1, and instrValid=1 from E2.
- Steady state with stall=0: 3 cycles per instruction; romRdEn is high one cycle in three.
- Acceptance edge: instrValid=1 and stall=0. instrValid is 0 for the two cycles after acceptance.
- Branch edge: instrValid=0 from the next cycle. The target word is valid 2 cycles after the redirect REQ cycle.
- Branch and stall asserted together in VALID: the redirect wins and the held word is dropped.
- romData is sampled only at the end of WAIT; at all other times it is don't-care.
- All outputs are registered or decoded from state and pc only. There is no combinational path from inputs to outputs.

## Structure
- Shared package cpu_pkg contains:
  - the fetch_state_t enum (IDLE, REQ, WAIT, VALID, HALT)
  - HALT_INSTR = 32'd0, shared with the decoder's halt test
  - PC_STEP = 4
  - PC_READ_OFFSET = 8
- Single module with no sub-module. The pc incrementer and redirect mux are inline.
- The ROM is external. The bench supplies a behavioral model with one-cycle latency.

## Test plan
- Straight-line fetch: ROM words 0..3 = 32'hE2811001, 32'hE2822002, 32'hE0803001, 32'h0; start pulse, stall=0 → instruccion sequence matches, pcOut 0,4,8,C, each word valid exactly 1 cycle, 3 cycles apart; halted=1 after word 3 accepted, romRdEn stays 0 afterwards.
- Stall hold: stall=1 for 5 cycles while word at 0x4 is valid → instruccion, pcOut=0x4 and instrValid held 5 cycles, no romRdEn; release → next REQ uses romAddr=2.
- Branch: branchTaken=1 with branchTarget=32'h0000_0041 during WAIT of the fetch at 0x8 → word 0x8 never valid; next romAddr=0x10, pcOut=0x40, pcPlus8=0x48.
- Branch with stall: stall=1 and branchTaken=1 (target 0x20) in the same VALID cycle → held word dropped, romAddr=0x8 on the following cycle.
- Wrap: RESET_PC=32'hFFFF_FFFC, ADDR_W=10 → first fetch romAddr=10'h3FF, second fetch pcOut=0 and romAddr=0.
- Reset mid-operation: rst_n=0 during WAIT → next cycle IDLE, instrValid=0, halted=0, pc=RESET_PC; no fetch until start is reasserted.
